// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone B3 master turning commands into single or incrementing-burst cycles,
// with a write-stream holding register, a read-data stream and an ack timeout.
module wb_burst_master #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int LW     = 8,
    parameter int TO_CYC = 1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [LW-1:0]   cmd_len,
    input  logic [DW-1:0]   wr_data,
    input  logic            wr_valid,
    output logic            wr_ready,
    output logic [DW-1:0]   rd_data,
    output logic            rd_valid,
    output logic            done,
    output logic            err,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i
);
    localparam int TW = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t        r_state, w_state_n;
    logic          r_cyc, r_stb, r_we, r_rd_valid, r_done, r_err;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_dat, r_rd_data;
    logic [LW-1:0] r_beats, r_idx, r_loaded;
    logic [TW-1:0] r_to;
    logic          w_start, w_ack, w_last, w_fin, w_abort, w_wr_ready, w_pop;

    assign cmd_ready  = (r_state == IDLE) && !r_done && !r_err;
    assign w_start    = cmd_valid && cmd_ready;
    assign w_ack      = r_stb && wb_ack_i;
    assign w_last     = r_idx == r_beats - LW'(1);
    assign w_fin      = w_ack && w_last;
    assign w_abort    = r_cyc && !w_ack && (r_to == TW'(TO_CYC - 1));
    assign w_wr_ready = (r_state == WR) && (!r_stb || wb_ack_i) && (r_loaded < r_beats) && !w_abort;
    assign w_pop      = wr_valid && w_wr_ready;

    assign wr_ready  = w_wr_ready;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign done      = r_done;
    assign err       = r_err;
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_stb;
    assign wb_we_o   = r_we;
    assign wb_addr_o = r_addr;
    assign wb_dat_o  = r_dat;
    assign wb_sel_o  = {(DW/8){1'b1}};
    assign wb_cti_o  = (!r_cyc || r_beats == LW'(1)) ? 3'b000 : w_last ? 3'b111 : 3'b010;

    always_comb begin
        w_state_n = r_state;
        w_state_n = (r_state == IDLE) ? (w_start ? (cmd_we ? WR : RD) : IDLE)
                                      : ((w_fin || w_abort) ? IDLE : r_state);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= IDLE;
        else          r_state <= w_state_n;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_dat      <= '0;
            r_rd_data  <= '0;
            r_beats    <= '0;
            r_idx      <= '0;
            r_loaded   <= '0;
            r_to       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
            if (w_ack) begin
                r_addr <= r_addr + AW'(DW/8);
                r_idx  <= r_idx + LW'(1);
                r_to   <= '0;
            end else if (r_cyc) begin
                r_to <= r_to + TW'(1);
            end
            if (w_ack && !r_we) begin
                r_rd_data  <= wb_dat_i;
                r_rd_valid <= 1'b1;
            end
            // a fresh word keeps the strobe up even when the current one is acked
            if (w_pop) begin
                r_dat    <= wr_data;
                r_loaded <= r_loaded + LW'(1);
                r_stb    <= 1'b1;
            end else if (w_ack && r_we) begin
                r_stb <= 1'b0;
            end
            if (w_start) begin
                r_we     <= cmd_we;
                r_addr   <= cmd_addr;
                r_beats  <= (cmd_len == '0) ? LW'(1) : cmd_len;
                r_idx    <= '0;
                r_loaded <= '0;
                r_to     <= '0;
                r_cyc    <= 1'b1;
                r_stb    <= !cmd_we;
            end else if (w_fin || w_abort) begin
                r_cyc  <= 1'b0;
                r_stb  <= 1'b0;
                r_we   <= 1'b0;
                r_done <= w_fin;
                r_err  <= w_abort;
            end
        end
    end
endmodule
